// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, FSM state type and arctangent table
// Fixed point is Q2.62 throughout: one sign bit, one integer bit, 62 fraction bits.
package cordic_pkg;

  localparam int DATA_W   = 64;
  localparam int FRAC_W   = 62;
  localparam int ITER_MAX = 63;

  localparam logic signed [DATA_W-1:0] Q_ONE = 64'sh4000_0000_0000_0000;
  localparam logic signed [DATA_W-1:0] K_INV = 64'sd2800459870029452953;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } state_t;

  // atan(2^-i) from its Taylor series in 124 fraction bits, then rounded to 62.
  // Entry 0 converges too slowly for the series, so pi/4 is given directly.
  function automatic logic [64*64-1:0] build_atan_tab();
    logic [64*64-1:0] tab;
    logic [127:0]     acc;
    logic [127:0]     term;
    int               sh;
    tab          = '0;
    tab[63:0]    = 64'h3243_F6A8_885A_308D;
    for (int i = 1; i <= ITER_MAX; i++) begin
      acc = '0;
      for (int k = 0; k < 63; k++) begin
        sh = 124 - i * (2 * k + 1);
        if (sh >= 0) begin
          term = (128'd1 << sh) / 128'(2 * k + 1);
          if (k % 2 == 0) acc = acc + term;
          else            acc = acc - term;
        end
      end
      // Ties round down: the truncated series always sits just above the true value.
      acc = (acc + (128'd1 << (124 - FRAC_W - 1)) - 128'd1) >> (124 - FRAC_W);
      tab[i*64 +: 64] = acc[63:0];
    end
    return tab;
  endfunction

  localparam logic [64*64-1:0] ATAN_TAB = build_atan_tab();

  function automatic logic signed [DATA_W-1:0] atan_tab(input logic [5:0] idx);
    return $signed(ATAN_TAB[{idx, 6'b0} +: 64]);
  endfunction

endpackage

// File: rtl/cordic_arith_shift64.sv
// rtl/cordic_arith_shift64.sv - six-stage logarithmic arithmetic right shifter, 64 bit
module cordic_arith_shift64 (
  input  logic signed [63:0] data,
  input  logic        [5:0]  amount,
  output logic signed [63:0] result
);

  logic signed [63:0] s1, s2, s3, s4, s5;

  assign s1     = amount[0] ? (data >>> 1)  : data;
  assign s2     = amount[1] ? (s1   >>> 2)  : s1;
  assign s3     = amount[2] ? (s2   >>> 4)  : s2;
  assign s4     = amount[3] ? (s3   >>> 8)  : s3;
  assign s5     = amount[4] ? (s4   >>> 16) : s4;
  assign result = amount[5] ? (s5   >>> 32) : s5;

endmodule

// File: rtl/cordic_iteration_engine.sv
// rtl/cordic_iteration_engine.sv - sequential CORDIC engine, one micro-rotation per clock
// Rotation mode drives z toward 0, vectoring mode drives y toward 0; no gain compensation.
module cordic_iteration_engine
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 48
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic signed [63:0] x_in,
  input  logic signed [63:0] y_in,
  input  logic signed [63:0] z_in,
  output logic               busy,
  output logic               done,
  output logic signed [63:0] x_out,
  output logic signed [63:0] y_out,
  output logic signed [63:0] z_out
);

  localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

  state_t             state, state_next;
  logic signed [63:0] x_r, y_r, z_r;
  logic signed [63:0] x_sh, y_sh, atan_i;
  logic signed [63:0] x_step, y_step, z_step;
  logic               mode_r, d_pos;
  logic        [5:0]  iter;

  cordic_arith_shift64 u_shift_x (.data(x_r), .amount(iter), .result(x_sh));
  cordic_arith_shift64 u_shift_y (.data(y_r), .amount(iter), .result(y_sh));

  assign atan_i = atan_tab(iter);
  assign d_pos  = mode_r ? y_r[63] : ~z_r[63];
  assign x_step = d_pos ? (x_r - y_sh)   : (x_r + y_sh);
  assign y_step = d_pos ? (y_r + x_sh)   : (y_r - x_sh);
  assign z_step = d_pos ? (z_r - atan_i) : (z_r + atan_i);
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_RUN;
      ST_RUN:    if (iter == LAST_ITER) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Abort suppresses every datapath update, so the result registers keep their old values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      mode_r <= 1'b0;
      iter   <= '0;
      done   <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else begin
      done <= 1'b0;
      if (!abort) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              x_r    <= x_in;
              y_r    <= y_in;
              z_r    <= z_in;
              mode_r <= mode;
              iter   <= '0;
            end
          end
          ST_RUN: begin
            x_r <= x_step;
            y_r <= y_step;
            z_r <= z_step;
            if (iter != LAST_ITER) iter <= iter + 6'd1;
          end
          ST_FINISH: begin
            x_out <= x_r;
            y_out <= y_r;
            z_out <= z_r;
            done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cordic_iteration_engine.sv
// tb/tb_cordic_iteration_engine.sv - scoreboard bench for cordic_iteration_engine
`timescale 1ns/1ps
module tb_cordic_iteration_engine;
  import cordic_pkg::*;

  localparam real Q62 = 4611686018427387904.0;
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, start1 = 1'b0, abort = 1'b0, mode = 1'b0;
  logic signed [63:0] x_in = '0, y_in = '0, z_in = '0;
  logic busy, done, busy1, done1;
  logic signed [63:0] x_out, y_out, z_out, x_out1, y_out1, z_out1;

  int errors = 0;
  int checks = 0;
  real k48;

  typedef struct {
    real x; real y; real z;
    real tx; real ty; real tz;
  } exp_t;
  exp_t sb[$];

  cordic_iteration_engine #(.ITERATIONS(48)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  cordic_iteration_engine #(.ITERATIONS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .busy(busy1), .done(done1),
    .x_out(x_out1), .y_out(y_out1), .z_out(z_out1)
  );

  always #5 clk = ~clk;

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  task automatic run_op(input logic signed [63:0] xv, input logic signed [63:0] yv,
                        input logic signed [63:0] zv, input logic m, output int lat);
    @(negedge clk);
    x_in = xv; y_in = yv; z_in = zv; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", busy, done);
    end
    checks++;
    if (x_out !== 64'sd0 || y_out !== 64'sd0 || z_out !== 64'sd0) begin
      errors++; $display("FAIL reset_out: x=%0h y=%0h z=%0h, want 0", x_out, y_out, z_out);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_rotation();
    int lat; exp_t e;
    sb.push_back('{k48 * Q62 / 4.0, 0.0, 0.0, 65536.0, 65536.0, 131072.0});
    run_op(64'sh1000_0000_0000_0000, 64'sd0, 64'sd0, 1'b0, lat);
    checks++;
    if (lat != 49) begin errors++; $display("FAIL rot_latency: got %0d cycles, want 49", lat); end
    e = sb.pop_front();
    checks++;
    if (absr(real'(x_out) - e.x) > e.tx) begin errors++; $display("FAIL rot_x: got %0d want %0.0f", x_out, e.x); end
    checks++;
    if (absr(real'(y_out) - e.y) > e.ty) begin errors++; $display("FAIL rot_y: got %0d want %0.0f", y_out, e.y); end
    checks++;
    if (absr(real'(z_out) - e.z) > e.tz) begin errors++; $display("FAIL rot_z: got %0d want %0.0f", z_out, e.z); end
  endtask

  task automatic test_vectoring();
    int lat; exp_t e;
    sb.push_back('{k48 * $sqrt(2.0) * Q62 / 4.0, 0.0, real'(64'sh3243_F6A8_885A_308D),
                   131072.0, 65536.0, 131072.0});
    run_op(64'sh1000_0000_0000_0000, 64'sh1000_0000_0000_0000, 64'sd0, 1'b1, lat);
    checks++;
    if (lat != 49) begin errors++; $display("FAIL vec_latency: got %0d cycles, want 49", lat); end
    e = sb.pop_front();
    checks++;
    if (absr(real'(x_out) - e.x) > e.tx) begin errors++; $display("FAIL vec_x: got %0d want %0.0f", x_out, e.x); end
    checks++;
    if (absr(real'(y_out) - e.y) > e.ty) begin errors++; $display("FAIL vec_y: got %0d want %0.0f", y_out, e.y); end
    checks++;
    if (absr(real'(z_out) - e.z) > e.tz) begin errors++; $display("FAIL vec_z: got %0d want %0.0f", z_out, e.z); end
  endtask

  task automatic test_sin_cos();
    int lat; exp_t e; longint zv;
    zv = longint'(PI / 6.0 * Q62);
    sb.push_back('{$sqrt(3.0) / 2.0 * Q62, Q62 / 2.0, 0.0, 262144.0, 262144.0, 262144.0});
    run_op(K_INV, 64'sd0, 64'(zv), 1'b0, lat);
    e = sb.pop_front();
    checks++;
    if (absr(real'(x_out) - e.x) > e.tx) begin errors++; $display("FAIL cos_x: got %0d want %0.0f", x_out, e.x); end
    checks++;
    if (absr(real'(y_out) - e.y) > e.ty) begin errors++; $display("FAIL sin_y: got %0d want %0.0f", y_out, e.y); end
    checks++;
    if (absr(real'(z_out) - e.z) > e.tz) begin errors++; $display("FAIL sincos_z: got %0d want %0.0f", z_out, e.z); end
  endtask

  task automatic test_back_to_back();
    int exp_edge[$];
    int next_free = 0, n_done = 0, busy_bad = 0, ee;
    exp_t e;
    for (int t = 0; t <= 105; t++) begin
      @(negedge clk);
      if (t >= 1 && t <= 100 && busy !== !done) busy_bad++;
      if (done === 1'b1) begin
        n_done++;
        if (exp_edge.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_extra_done: done at cycle %0d, none expected", t - 1);
        end else begin
          ee = exp_edge.pop_front();
          e  = sb.pop_front();
          checks++;
          if (t - 1 != ee) begin errors++; $display("FAIL b2b_done_cycle: got %0d want %0d", t - 1, ee); end
          checks++;
          if (absr(real'(x_out) - e.x) > e.tx) begin errors++; $display("FAIL b2b_x: got %0d want %0.0f", x_out, e.x); end
        end
      end
      if (t < 100) begin
        x_in = 64'sh1000_0000_0000_0000; y_in = '0; z_in = '0; mode = 1'b0; start = 1'b1;
        if (t >= next_free) begin
          exp_edge.push_back(t + 49);
          sb.push_back('{k48 * Q62 / 4.0, 0.0, 0.0, 65536.0, 65536.0, 131072.0});
          next_free = t + 50;
        end
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (n_done != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL b2b_busy: %0d cycles with busy != !done, want 0", busy_bad); end
    sb.delete();
  endtask

  task automatic test_abort();
    int n_done = 0, lat;
    real ex = k48 * Q62 / 4.0;
    @(negedge clk);
    x_in = 64'sh1000_0000_0000_0000; y_in = 64'sh1000_0000_0000_0000; z_in = '0; mode = 1'b1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle: busy=%b want 0", busy); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: busy=%b want 0", busy); end
    if (done === 1'b1) n_done++;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", n_done); end
    checks++;
    if (absr(real'(x_out) - ex) > 65536.0 || absr(real'(y_out)) > 65536.0 || absr(real'(z_out)) > 131072.0) begin
      errors++; $display("FAIL abort_outputs: x=%0d y=%0d z=%0d, want previous rotation result", x_out, y_out, z_out);
    end
    sb.push_back('{k48 * $sqrt(2.0) * Q62 / 4.0, 0.0, real'(64'sh3243_F6A8_885A_308D),
                   131072.0, 65536.0, 131072.0});
    run_op(64'sh1000_0000_0000_0000, 64'sh1000_0000_0000_0000, 64'sd0, 1'b1, lat);
    checks++;
    if (lat != 49) begin errors++; $display("FAIL abort_restart_latency: got %0d want 49", lat); end
    begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (absr(real'(z_out) - e.z) > e.tz) begin errors++; $display("FAIL abort_restart_z: got %0d want %0.0f", z_out, e.z); end
    end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    @(negedge clk);
    x_in = 64'sh0800_0000_0000_0000; y_in = '0; z_in = '0; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (x_out !== 64'sd0 || y_out !== 64'sd0 || z_out !== 64'sd0) begin
      errors++; $display("FAIL midreset_out: x=%0h y=%0h z=%0h want 0", x_out, y_out, z_out);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: busy=%b done=%b want 0 0", busy, done); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses want 0", n_done); end
  endtask

  task automatic test_single_iteration();
    int lat = 0;
    @(negedge clk);
    x_in = 64'sh1000_0000_0000_0000; y_in = '0; z_in = '0; mode = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (done1 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL iter1_latency: got %0d want 2", lat); end
    checks++;
    if (x_out1 !== 64'sh1000_0000_0000_0000) begin errors++; $display("FAIL iter1_x: got %0h want 1000000000000000", x_out1); end
    checks++;
    if (y_out1 !== 64'sh1000_0000_0000_0000) begin errors++; $display("FAIL iter1_y: got %0h want 1000000000000000", y_out1); end
    checks++;
    if (z_out1 !== -64'sh3243_F6A8_885A_308D) begin errors++; $display("FAIL iter1_z: got %0h want cdbc095777a5cf73", z_out1); end
  endtask

  initial begin
    k48 = 1.0;
    for (int i = 0; i < 48; i++) k48 = k48 * $sqrt(1.0 + 2.0 ** (-2 * i));
    test_reset();
    test_rotation();
    test_vectoring();
    test_sin_cos();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_single_iteration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
